// File: rtl/fpu_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg
// Shared FP32 definitions used by the FP ALU, its result buffer and benches:
//   - word and field widths/positions of an IEEE-754 single
//   - exponent all-ones pattern and the canonical quiet NaN
//   - is_nan / is_inf classification helpers
//   - res_entry_t: one buffered ALU beat {overflow flag, result word}
// -----------------------------------------------------------------------------
package fpu_pkg;

  localparam int FP_W     = 32;
  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;
  localparam int MAN_LSB  = 0;
  localparam int EXP_LSB  = 23;
  localparam int SIGN_POS = 31;

  localparam logic [EXP_W-1:0] EXP_ALL_ONES = 8'hFF;
  localparam logic [FP_W-1:0]  CANON_NAN    = 32'h7FC00000;

  typedef struct packed {
    logic            ovf;
    logic [FP_W-1:0] data;
  } res_entry_t;

  // NaN: exponent all ones with a non-zero mantissa.
  function automatic logic is_nan(input logic [FP_W-1:0] v);
    return (v[EXP_LSB +: EXP_W] == EXP_ALL_ONES) &&
           (v[MAN_LSB +: MAN_W] != {MAN_W{1'b0}});
  endfunction

  // Infinity: exponent all ones with a zero mantissa (either sign).
  function automatic logic is_inf(input logic [FP_W-1:0] v);
    return (v[EXP_LSB +: EXP_W] == EXP_ALL_ONES) &&
           (v[MAN_LSB +: MAN_W] == {MAN_W{1'b0}});
  endfunction

endpackage

// File: rtl/fpu_res_ram.sv
// -----------------------------------------------------------------------------
// fpu_res_ram
// DEPTH x 33-bit storage for buffered ALU results. One synchronous write
// port, one asynchronous read port. No reset: validity is tracked by the
// owner's occupancy counter, never by the array contents.
// Ports:
//   clk    in   write clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   {ovf, data} entry to store
//   raddr  in   read address
//   rdata  out  entry at raddr (combinational)
// -----------------------------------------------------------------------------
module fpu_res_ram
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  res_entry_t    wdata,
  input  logic [AW-1:0] raddr,
  output res_entry_t    rdata
);

  res_entry_t mem_q [DEPTH];

  // Storage write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fpu_result_buffer.sv
// -----------------------------------------------------------------------------
// fpu_result_buffer
// Captures every beat of the 3-stage FP32 ALU (which cannot be stalled) into
// a first-word-fall-through FIFO, presents it on a valid/ready handshake and
// issues per-cycle credit so upstream never has more results outstanding
// (queued + still in the ALU pipeline) than the FIFO can hold.
// Optional macro FPU_RES_STICKY_EN enables the sticky exception status
// registers; when undefined sticky_ovf/sticky_nan are tied low.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   alu_issue / issue_ok     upstream issue strobe / credit available
//   alu_res/alu_ovf/_vld     ALU result beat
//   out_data/out_ovf/out_vld head entry, out_rdy consumer accept
//   count                    FIFO occupancy
//   err                      sticky protocol error (overrun, over-issue,
//                            unmatched result)
//   sticky_ovf/sticky_nan    accumulated exception status, sticky_clr clears
// -----------------------------------------------------------------------------
module fpu_result_buffer
  import fpu_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int PIPE_LAT = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_issue,
  output logic                       issue_ok,
  input  logic [31:0]                alu_res,
  input  logic                       alu_ovf,
  input  logic                       alu_res_vld,
  output logic [31:0]                out_data,
  output logic                       out_ovf,
  output logic                       out_vld,
  input  logic                       out_rdy,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       err,
  output logic                       sticky_ovf,
  output logic                       sticky_nan,
  input  logic                       sticky_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(PIPE_LAT+DEPTH+1);
  localparam int SW = ((CW > IW) ? CW : IW) + 1;

  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] infl_q, infl_d;
  logic          err_q, err_d;

  logic       push_s, pop_s, full_s, wr_en_s, drop_s, underflow_s;
  logic [SW-1:0] credit_sum_s;
  res_entry_t head_entry_s;

  assign push_s  = alu_res_vld;
  assign pop_s   = (count_q != {CW{1'b0}}) && out_rdy;
  assign full_s  = (count_q == CW'(DEPTH));
  // A push into a full FIFO is only accepted when the head leaves this cycle.
  assign wr_en_s = push_s && (!full_s || pop_s);
  assign drop_s  = push_s && full_s && !pop_s;
  assign underflow_s = alu_res_vld && !alu_issue && (infl_q == {IW{1'b0}});

  // Credit looks only at registered state so alu_issue never feeds issue_ok.
  assign credit_sum_s = SW'(count_q) + SW'(infl_q);
  assign issue_ok     = (credit_sum_s < SW'(DEPTH));

  fpu_res_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (wr_en_s),
    .waddr (tail_q),
    .wdata ({alu_ovf, alu_res}),
    .raddr (head_q),
    .rdata (head_entry_s)
  );

  // Next-state for pointers, occupancy, in-flight credit and error flag.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    infl_d  = infl_q;

    // Pointers wrap naturally at DEPTH (power of two).
    if (wr_en_s) begin
      tail_d = tail_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      tail_d = tail_q;
    end
    if (pop_s) begin
      head_d = head_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      head_d = head_q;
    end

    case ({wr_en_s, pop_s})
      2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase

    case ({alu_issue, alu_res_vld})
      2'b10: begin
        if (infl_q == {IW{1'b1}}) begin
          infl_d = infl_q;
        end else begin
          infl_d = infl_q + {{(IW-1){1'b0}}, 1'b1};
        end
      end
      2'b01: begin
        if (infl_q == {IW{1'b0}}) begin
          infl_d = infl_q;
        end else begin
          infl_d = infl_q - {{(IW-1){1'b0}}, 1'b1};
        end
      end
      default: infl_d = infl_q;
    endcase

    err_d = err_q | drop_s | underflow_s | (alu_issue & ~issue_ok);
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= {AW{1'b0}};
      tail_q  <= {AW{1'b0}};
      count_q <= {CW{1'b0}};
      infl_q  <= {IW{1'b0}};
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      infl_q  <= infl_d;
      err_q   <= err_d;
    end
  end

  assign out_vld  = (count_q != {CW{1'b0}});
  // Stale array contents are masked so an empty buffer always shows zero.
  assign out_data = out_vld ? head_entry_s.data : 32'h0000_0000;
  assign out_ovf  = out_vld ? head_entry_s.ovf  : 1'b0;
  assign count    = count_q;
  assign err      = err_q;

`ifdef FPU_RES_STICKY_EN
  logic sticky_ovf_q, sticky_ovf_d, sticky_nan_q, sticky_nan_d;

  // Sticky status: a popped exception wins over a coincident clear.
  always_comb begin
    if (pop_s && head_entry_s.ovf) begin
      sticky_ovf_d = 1'b1;
    end else if (sticky_clr) begin
      sticky_ovf_d = 1'b0;
    end else begin
      sticky_ovf_d = sticky_ovf_q;
    end
    if (pop_s && is_nan(head_entry_s.data)) begin
      sticky_nan_d = 1'b1;
    end else if (sticky_clr) begin
      sticky_nan_d = 1'b0;
    end else begin
      sticky_nan_d = sticky_nan_q;
    end
  end

  // Sticky status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sticky_ovf_q <= 1'b0;
      sticky_nan_q <= 1'b0;
    end else begin
      sticky_ovf_q <= sticky_ovf_d;
      sticky_nan_q <= sticky_nan_d;
    end
  end

  assign sticky_ovf = sticky_ovf_q;
  assign sticky_nan = sticky_nan_q;
`else
  logic unused_sticky_clr_s;
  assign unused_sticky_clr_s = sticky_clr;
  assign sticky_ovf = 1'b0;
  assign sticky_nan = 1'b0;
`endif

endmodule
